// File: rtl/regfile_sb.sv
// Integer register file with pending-write scoreboard, optional writeback bypass
// and a one-entry-per-cycle clear sequence after reset.
module regfile_sb #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned AW     = $clog2(NREG),
    parameter bit          BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ready,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            we,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_data
);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [NREG-1:0] pending_q, pending_d;
    logic [XLEN-1:0] regs_q [NREG];

    logic run;
    logic wr_en;
    logic iss_en;
    logic fwd1, fwd2;

    assign run    = (state_q == StRun);
    assign ready  = run;
    // Traffic is only honoured once the clear sequence has finished.
    assign wr_en  = run && we && (rd_addr != '0);
    assign iss_en = run && iss_valid && (iss_rd != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StInit: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(NREG - 1)) begin
                    state_d = StRun;
                    cnt_d   = cnt_q;
                end
            end
            StRun: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    // A new producer supersedes the retiring one, so set is applied after clear.
    always_comb begin
        pending_d = pending_q;
        if (wr_en) begin
            pending_d[rd_addr] = 1'b0;
        end
        if (iss_en) begin
            pending_d[iss_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StInit;
            cnt_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == StInit) begin
                regs_q[cnt_q] <= '0;
            end else if (wr_en) begin
                regs_q[rd_addr] <= rd_data;
            end
        end
    end

    assign fwd1 = BYPASS && wr_en && (rd_addr == rs1_addr);
    assign fwd2 = BYPASS && wr_en && (rd_addr == rs2_addr);

    always_comb begin
        rs1_data = '0;
        if (run && (rs1_addr != '0)) begin
            rs1_data = fwd1 ? rd_data : regs_q[rs1_addr];
        end
    end

    always_comb begin
        rs2_data = '0;
        if (run && (rs2_addr != '0)) begin
            rs2_data = fwd2 ? rd_data : regs_q[rs2_addr];
        end
    end

    assign rs1_busy = pending_q[rs1_addr] && !fwd1;
    assign rs2_busy = pending_q[rs2_addr] && !fwd2;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: one forwarding and one non-forwarding
// instance share the same stimulus.
module tb_regfile_sb;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   rs1_addr, rs2_addr, iss_rd, rd_addr;
    logic            iss_valid, we;
    logic [XLEN-1:0] rd_data;

    logic            ready, rs1_busy, rs2_busy;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            ready_nb, rs1_busy_nb, rs2_busy_nb;
    logic [XLEN-1:0] rs1_data_nb, rs2_data_nb;

    int n_checks = 0;
    int n_fail   = 0;

    logic [XLEN-1:0] exp_q [$];
    logic [XLEN-1:0] exp_v;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1'b1)) u_dut (
        .clk(clk), .rst(rst), .ready(ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .we(we), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1'b0)) u_dut_nb (
        .clk(clk), .rst(rst), .ready(ready_nb),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data_nb), .rs2_data(rs2_data_nb),
        .rs1_busy(rs1_busy_nb), .rs2_busy(rs2_busy_nb),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .we(we), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    task automatic idle_inputs();
        iss_valid = 1'b0;
        iss_rd    = '0;
        we        = 1'b0;
        rd_addr   = '0;
        rd_data   = '0;
    endtask

    // Counts rising edges until ready, bounded so a stuck DUT still terminates.
    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            if (ready) break;
        end
    endtask

    task automatic test_reset();
        int cyc;
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        rs1_addr = 5'd5;
        rs2_addr = 5'd0;
        @(posedge clk);
        #1;
        n_checks++;
        if (ready !== 1'b0 || ready_nb !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b/%b want 0", ready, ready_nb);
        end
        n_checks++;
        if (rs1_data !== '0 || rs1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_read: got data %h busy %b want 0/0", rs1_data, rs1_busy);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_ready(cyc);
        n_checks++;
        if (cyc != 32 || ready_nb !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_latency: got %0d cycles (nb ready %b) want 32", cyc, ready_nb);
        end
    endtask

    task automatic test_reset_clear();
        int cyc;
        @(negedge clk);
        we = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEADBEEF;
        @(negedge clk);
        idle_inputs();
        rs1_addr = 5'd5;
        exp_q.push_back(32'hDEADBEEF);
        #1;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rs1_data !== exp_v) begin
            n_fail++;
            $display("FAIL pre_reset_x5: got %h want %h", rs1_data, exp_v);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(32'h0);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rs1_data !== exp_v || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL init_read_x5: got %h ready %b want %h ready 0", rs1_data, ready, exp_v);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_ready(cyc);
        n_checks++;
        if (cyc != 32) begin
            n_fail++;
            $display("FAIL reclear_latency: got %0d want 32", cyc);
        end
        exp_q.push_back(32'h0);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rs1_data !== exp_v || rs1_data_nb !== exp_v) begin
            n_fail++;
            $display("FAIL x5_cleared: got %h/%h want %h", rs1_data, rs1_data_nb, exp_v);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        we = 1'b1; rd_addr = 5'd7; rd_data = 32'h12345678;
        rs1_addr = 5'd7; rs2_addr = 5'd7;
        exp_q.push_back(32'h12345678);
        exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rs1_data !== exp_v || rs2_data !== exp_v) begin
            n_fail++;
            $display("FAIL bypass_fwd: got %h/%h want %h", rs1_data, rs2_data, exp_v);
        end
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rs1_data_nb !== exp_v || rs2_data_nb !== exp_v) begin
            n_fail++;
            $display("FAIL nobypass_old: got %h/%h want %h", rs1_data_nb, rs2_data_nb, exp_v);
        end
        @(posedge clk);
        exp_q.push_back(32'h12345678);
        #1;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rs1_data_nb !== exp_v || rs2_data_nb !== exp_v) begin
            n_fail++;
            $display("FAIL nobypass_new: got %h/%h want %h", rs1_data_nb, rs2_data_nb, exp_v);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_x0();
        @(negedge clk);
        we = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFFFFFF;
        iss_valid = 1'b1; iss_rd = 5'd0;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        #1;
        n_checks++;
        if (rs1_data !== '0 || rs2_data !== '0) begin
            n_fail++;
            $display("FAIL x0_comb: got %h/%h want 0", rs1_data, rs2_data);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (rs1_data !== '0 || rs1_data_nb !== '0 || rs1_busy !== 1'b0 || rs1_busy_nb !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_after: got %h/%h busy %b/%b want 0 not busy",
                     rs1_data, rs1_data_nb, rs1_busy, rs1_busy_nb);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        iss_valid = 1'b1; iss_rd = 5'd3; rs1_addr = 5'd3; rs2_addr = 5'd3;
        #1;
        n_checks++;
        if (rs1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_early: got %b want 0", rs1_busy);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (rs1_busy !== 1'b1 || rs2_busy_nb !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_set: got %b/%b want 1", rs1_busy, rs2_busy_nb);
        end
        @(negedge clk);
        iss_valid = 1'b0;
        repeat (2) @(negedge clk);
        we = 1'b1; rd_addr = 5'd3; rd_data = 32'hA5;
        exp_q.push_back(32'hA5);
        #1;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rs1_busy !== 1'b0 || rs1_data !== exp_v) begin
            n_fail++;
            $display("FAIL wb_fwd: got busy %b data %h want 0 %h", rs1_busy, rs1_data, exp_v);
        end
        n_checks++;
        if (rs1_busy_nb !== 1'b1) begin
            n_fail++;
            $display("FAIL wb_nofwd_busy: got %b want 1", rs1_busy_nb);
        end
        @(negedge clk);
        idle_inputs();
        exp_q.push_back(32'hA5);
        #1;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rs1_busy_nb !== 1'b0 || rs1_data_nb !== exp_v || rs2_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wb_settled: got busy %b data %h want 0 %h", rs1_busy_nb, rs1_data_nb, exp_v);
        end
    endtask

    task automatic test_set_clear();
        @(negedge clk);
        iss_valid = 1'b1; iss_rd = 5'd9;
        @(negedge clk);
        we = 1'b1; rd_addr = 5'd9; rd_data = 32'h0000_0099;
        rs1_addr = 5'd9;
        exp_q.push_back(32'h0000_0099);
        @(negedge clk);
        idle_inputs();
        #1;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rs1_data !== exp_v || rs1_data_nb !== exp_v) begin
            n_fail++;
            $display("FAIL setclr_data: got %h/%h want %h", rs1_data, rs1_data_nb, exp_v);
        end
        n_checks++;
        if (rs1_busy !== 1'b1 || rs1_busy_nb !== 1'b1) begin
            n_fail++;
            $display("FAIL setclr_pending: got %b/%b want 1", rs1_busy, rs1_busy_nb);
        end
        @(negedge clk);
        we = 1'b1; rd_addr = 5'd9; rd_data = 32'h0000_0999;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_midclear();
        int cyc;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        // Traffic to x4 during the whole clear must be discarded.
        we = 1'b1; rd_addr = 5'd4; rd_data = 32'h0000_0044;
        iss_valid = 1'b1; iss_rd = 5'd4;
        rs1_addr = 5'd4; rs2_addr = 5'd4;
        wait_ready(cyc);
        n_checks++;
        if (cyc != 32) begin
            n_fail++;
            $display("FAIL midclear_latency: got %0d want 32", cyc);
        end
        @(negedge clk);
        idle_inputs();
        exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rs1_data !== exp_v || rs2_data_nb !== exp_v || rs1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL init_ignored: got %h/%h busy %b want %h busy 0",
                     rs1_data, rs2_data_nb, rs1_busy, exp_v);
        end
    endtask

    initial begin
        rst = 1'b1;
        rs1_addr = '0;
        rs2_addr = '0;
        idle_inputs();
        test_reset();
        test_reset_clear();
        test_bypass();
        test_x0();
        test_scoreboard();
        test_set_clear();
        test_midclear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
